// File: rtl/exp_pkg.sv
// Shared types, constants and lookup tables for the bf16 exp pipeline.
// Optional status outputs are enabled by defining EXP_PIPE_STATUS_EN.
package exp_pkg;

  // Per-lane operand class, decided in the first stage
  typedef enum logic [1:0] {
    CLS_LO  = 2'd0,
    CLS_MID = 2'd1,
    CLS_HI  = 2'd2,
    CLS_NAN = 2'd3
  } exp_cls_e;

  // Exponent window served by the lookup tables
  localparam logic [7:0] EXP_LO = 8'd121;
  localparam logic [7:0] EXP_HI = 8'd133;

  localparam logic [15:0] BF16_NAN  = 16'h7FC0;
  localparam logic [15:0] BF16_PINF = 16'h7F80;
  localparam logic [15:0] BF16_ONE  = 16'h3F80;
  localparam logic [15:0] BF16_ZERO = 16'h0000;

  // Tables indexed by e - EXP_LO; entries 13..15 are padding so any 4-bit index is defined
  localparam logic [15:0] BASE_P [16] = '{
    16'h3F82, 16'h3F84, 16'h3F88, 16'h3F91, 16'h3FA4, 16'h3FD3, 16'h402D,
    16'h40EC, 16'h425A, 16'h453A, 16'h4B07, 16'h568F, 16'h6DA1,
    16'h0000, 16'h0000, 16'h0000
  };
  localparam logic [15:0] OFF_P [16] = '{
    16'd2, 16'd4, 16'd9, 16'd19, 16'd47, 16'd90, 16'd191,
    16'd366, 16'd736, 16'd1485, 16'd2952, 16'd5906, 16'd11817,
    16'd0, 16'd0, 16'd0
  };
  // base_n = bf16(exp(-2^(e-127))), off_n = base_n[e] - base_n[e+1]
  localparam logic [15:0] BASE_N [16] = '{
    16'h3F7C, 16'h3F78, 16'h3F70, 16'h3F62, 16'h3F47, 16'h3F1B, 16'h3EBC,
    16'h3E0B, 16'h3C96, 16'h39B0, 16'h33F2, 16'h2864, 16'h114B,
    16'h0000, 16'h0000, 16'h0000
  };
  localparam logic [15:0] OFF_N [16] = '{
    16'd4, 16'd8, 16'd14, 16'd27, 16'd44, 16'd95, 16'd177,
    16'd373, 16'd742, 16'd1470, 16'd2958, 16'd5913, 16'd4427,
    16'd0, 16'd0, 16'd0
  };

  function automatic exp_cls_e classify(input logic [7:0] e, input logic [6:0] m);
    if (e == 8'hFF && m != 7'd0) return CLS_NAN;
    else if (e > EXP_HI)         return CLS_HI;
    else if (e < EXP_LO)         return CLS_LO;
    else                         return CLS_MID;
  endfunction

  function automatic logic [3:0] tbl_idx(input logic [7:0] e);
    logic [7:0] d;
    d = e - EXP_LO;
    return d[3:0];
  endfunction

endpackage

// File: rtl/exp_lane.sv
// One bf16 exp lane: classify, table lookup + multiply, add/subtract + select.
// Stage loads are commanded by the parent; ovf/unf exist only with EXP_PIPE_STATUS_EN.
module exp_lane
  import exp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s1_en,
  input  logic        s2_en,
  input  logic        s3_en,
  input  logic [15:0] x,
  output logic [15:0] y
`ifdef EXP_PIPE_STATUS_EN
  ,
  output logic        ovf,
  output logic        unf
`endif
);

  exp_cls_e    cls_in;
  logic [3:0]  idx_in;

  exp_cls_e    cls1_reg;
  logic        sign1_reg;
  logic [3:0]  idx1_reg;
  logic [6:0]  man1_reg;

  logic [15:0] base_sel;
  logic [15:0] off_sel;
  logic [22:0] prod;

  exp_cls_e    cls2_reg;
  logic        sign2_reg;
  logic [15:0] base2_reg;
  logic [15:0] frac2_reg;

  logic [15:0] sum;
  logic [16:0] diff;
  logic [15:0] y_next;
  logic [15:0] y_reg;

  // Classify the raw operand; non-MID classes use index 0 so the lookup stays defined
  always_comb begin
    cls_in = classify(x[14:7], x[6:0]);
    idx_in = (cls_in == CLS_MID) ? tbl_idx(x[14:7]) : 4'd0;
  end

  // S1: capture class, sign, table index and mantissa
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls1_reg  <= CLS_LO;
      sign1_reg <= 1'b0;
      idx1_reg  <= 4'd0;
      man1_reg  <= 7'd0;
    end else if (s1_en) begin
      cls1_reg  <= cls_in;
      sign1_reg <= x[15];
      idx1_reg  <= idx_in;
      man1_reg  <= x[6:0];
    end
  end

  // Sign picks the positive or negative table; the fraction is the top 16 bits of m*off
  always_comb begin
    base_sel = sign1_reg ? BASE_N[idx1_reg] : BASE_P[idx1_reg];
    off_sel  = sign1_reg ? OFF_N[idx1_reg]  : OFF_P[idx1_reg];
    prod     = 23'(man1_reg) * 23'(off_sel);
  end

  // S2: hold base and truncated fraction for the final add/subtract
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls2_reg  <= CLS_LO;
      sign2_reg <= 1'b0;
      base2_reg <= 16'd0;
      frac2_reg <= 16'd0;
    end else if (s2_en) begin
      cls2_reg  <= cls1_reg;
      sign2_reg <= sign1_reg;
      base2_reg <= base_sel;
      frac2_reg <= prod[22:7];
    end
  end

  // Result select; a borrow out of the negative-side subtraction clamps to zero
  always_comb begin
    sum  = base2_reg + frac2_reg;
    diff = {1'b0, base2_reg} - {1'b0, frac2_reg};
    case (cls2_reg)
      CLS_NAN: y_next = BF16_NAN;
      CLS_HI:  y_next = sign2_reg ? BF16_ZERO : BF16_PINF;
      CLS_LO:  y_next = BF16_ONE;
      default: y_next = sign2_reg ? (diff[16] ? BF16_ZERO : diff[15:0]) : sum;
    endcase
  end

  // S3: output register, reset to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      y_reg <= 16'd0;
    else if (s3_en)
      y_reg <= y_next;
  end

  assign y = y_reg;

`ifdef EXP_PIPE_STATUS_EN
  logic ovf_next, unf_next, ovf_reg, unf_reg;

  // Saturation flags travel with the result they describe
  always_comb begin
    ovf_next = (cls2_reg == CLS_HI) && !sign2_reg;
    unf_next = ((cls2_reg == CLS_HI) && sign2_reg) ||
               ((cls2_reg == CLS_MID) && sign2_reg && diff[16]);
  end

  // Flag registers aligned with y_reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else if (s3_en) begin
      ovf_reg <= ovf_next;
      unf_reg <= unf_next;
    end
  end

  assign ovf = ovf_reg;
  assign unf = unf_reg;
`endif

endmodule

// File: rtl/exp_pipe.sv
// Three-stage bf16 exp(x) pipeline over LANES lanes with valid/ready handshake
// and bubble collapsing. EXP_PIPE_STATUS_EN adds out_ovf/out_unf/sat_count.
module exp_pipe
  import exp_pkg::*;
#(
  parameter int LANES = 4,
  parameter int TAG_W = 4
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*LANES-1:0]   in_data,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*LANES-1:0]   out_data,
  output logic [TAG_W-1:0]      out_tag
`ifdef EXP_PIPE_STATUS_EN
  ,
  output logic [LANES-1:0]      out_ovf,
  output logic [LANES-1:0]      out_unf,
  output logic [15:0]           sat_count
`endif
);

  logic             v1_reg, v2_reg, v3_reg;
  logic [TAG_W-1:0] tag1_reg, tag2_reg, tag3_reg;
  logic             ready1, ready2, ready3;
  logic             ld1, ld2, ld3;

  // A stage is ready when empty or when its occupant moves on this cycle
  always_comb begin
    ready3 = ~v3_reg | out_ready;
    ready2 = ~v2_reg | ready3;
    ready1 = ~v1_reg | ready2;
    ld1    = in_valid & ready1;
    ld2    = v1_reg & ready2;
    ld3    = v2_reg & ready3;
  end

  assign in_ready  = ready1;
  assign out_valid = v3_reg;
  assign out_tag   = tag3_reg;

  // Stage valid bits advance whenever the stage is ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
    end else begin
      if (ready1) v1_reg <= in_valid;
      if (ready2) v2_reg <= v1_reg;
      if (ready3) v3_reg <= v2_reg;
    end
  end

  // Tags ride alongside the lane data, loaded only with real beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag1_reg <= '0;
      tag2_reg <= '0;
      tag3_reg <= '0;
    end else begin
      if (ld1) tag1_reg <= in_tag;
      if (ld2) tag2_reg <= tag1_reg;
      if (ld3) tag3_reg <= tag2_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      exp_lane u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .s1_en (ld1),
        .s2_en (ld2),
        .s3_en (ld3),
        .x     (in_data[16*gi +: 16]),
        .y     (out_data[16*gi +: 16])
`ifdef EXP_PIPE_STATUS_EN
        ,
        .ovf   (out_ovf[gi]),
        .unf   (out_unf[gi])
`endif
      );
    end
  endgenerate

`ifdef EXP_PIPE_STATUS_EN
  logic [15:0] sat_count_reg, sat_count_next;

  // Count delivered beats carrying any saturation flag, sticking at FFFF
  always_comb begin
    sat_count_next = sat_count_reg;
    if (v3_reg && out_ready && ((|out_ovf) || (|out_unf)) && sat_count_reg != 16'hFFFF)
      sat_count_next = sat_count_reg + 16'd1;
  end

  // Saturation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_count_reg <= 16'd0;
    else
      sat_count_reg <= sat_count_next;
  end

  assign sat_count = sat_count_reg;
`endif

endmodule

// File: tb/tb_exp_pipe.sv
// Directed bench for exp_pipe: reset, latency, vector table, stalled stream,
// mid-stream reset and (with EXP_PIPE_STATUS_EN) saturation status.
module tb_exp_pipe;

  localparam int LANES = 4;
  localparam int TAG_W = 4;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [16*LANES-1:0] in_data;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [16*LANES-1:0] out_data;
  logic [TAG_W-1:0]    out_tag;
`ifdef EXP_PIPE_STATUS_EN
  logic [LANES-1:0]    out_ovf;
  logic [LANES-1:0]    out_unf;
  logic [15:0]         sat_count;
`endif

  exp_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef EXP_PIPE_STATUS_EN
    ,
    .out_ovf   (out_ovf),
    .out_unf   (out_unf),
    .sat_count (sat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
  } vec_t;

  vec_t vecs [7];

  // Single-lane reference pairs for the streaming test
  logic [15:0] px [8];
  logic [15:0] py [8];

  function automatic logic [63:0] mk(input int k, input bit want_y);
    logic [63:0] r;
    int idx;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      idx = (k + 2 * l) % 8;
      r[16*l +: 16] = want_y ? py[idx] : px[idx];
    end
    return r;
  endfunction

  // Present one beat, then wait (bounded) for a result to appear
  task automatic push_wait(input logic [63:0] x, input logic [3:0] tag);
    int n;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = x;
    in_tag    = tag;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check(out_valid == 1'b1, "out_valid_wait", 64'(out_valid), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, recv, cyc;
    bit held, stale;
    logic [63:0] held_data;
    logic [3:0] held_tag;

    vecs[0] = '{x: 64'h3F80_3F80_3F80_3F80, y: 64'h402D_402D_402D_402D};
    vecs[1] = '{x: 64'hC000_4000_BF80_3FC0, y: 64'h3E0B_40EC_3EBC_408C};
    vecs[2] = '{x: 64'h3C00_7FC1_C300_4300, y: 64'h3F80_7FC0_0000_7F80};
    vecs[3] = '{x: 64'h0000_FFC0_FF80_7F80, y: 64'h3F80_7FC0_0000_7F80};
    vecs[4] = '{x: 64'hC2FF_4280_BC80_3C80, y: 64'h0023_6DA1_3F7C_3F82};
    vecs[5] = '{x: 64'h40A0_BFC0_437F_3C7F, y: 64'h4312_3E64_7F80_3F80};
    vecs[6] = '{x: 64'h3E80_C100_BE00_C080, y: 64'h3FA4_39B0_3F62_3C96};

    px[0] = 16'h3F80; py[0] = 16'h402D;
    px[1] = 16'h3FC0; py[1] = 16'h408C;
    px[2] = 16'hBF80; py[2] = 16'h3EBC;
    px[3] = 16'h4300; py[3] = 16'h7F80;
    px[4] = 16'hC300; py[4] = 16'h0000;
    px[5] = 16'h7FC1; py[5] = 16'h7FC0;
    px[6] = 16'h3C00; py[6] = 16'h3F80;
    px[7] = 16'hBFC0; py[7] = 16'h3E64;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
    check(out_data == '0,    "rst_out_data", out_data, 64'd0);
    check(out_tag == '0,     "rst_out_tag", 64'(out_tag), 64'd0);
    check(in_ready == 1'b1,  "rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check(in_ready == 1'b1, "post_rst_in_ready", 64'(in_ready), 64'd1);

    // Latency: beat taken on edge 1, result visible after edge 3
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 64'h3F80_3F80_3F80_3F80;
    in_tag   = 4'h1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check(out_valid == 1'b0, "lat_early", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check(out_valid == 1'b1, "lat_valid", 64'(out_valid), 64'd1);
    check(out_data[15:0] == 16'h402D, "lat_lane0", 64'(out_data[15:0]), 64'h402D);
    check(out_tag == 4'h1, "lat_tag", 64'(out_tag), 64'h1);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      push_wait(vecs[i].x, 4'(i + 2));
      $display("vec %0d x=%h y=%h tag=%h", i, vecs[i].x, out_data, out_tag);
      check(out_data == vecs[i].y, $sformatf("vec%0d_data", i), out_data, vecs[i].y);
      check(out_tag == 4'(i + 2), $sformatf("vec%0d_tag", i), 64'(out_tag), 64'(i + 2));
    end

    // Ten back-to-back beats with out_ready pattern 1,0,0
    sent = 0; recv = 0; cyc = 0; held = 1'b0;
    held_data = '0; held_tag = '0;
    while (recv < 10 && cyc < 200) begin
      @(negedge clk);
      out_ready = (cyc % 3 == 0);
      if (sent < 10) begin
        in_valid = 1'b1;
        in_data  = mk(sent, 1'b0);
        in_tag   = 4'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held)
        check(out_valid && out_data == held_data && out_tag == held_tag,
              "stall_stable", out_data, held_data);
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        $display("stream beat %0d tag=%h data=%h", recv, out_tag, out_data);
        check(out_data == mk(recv, 1'b1), $sformatf("stream%0d_data", recv), out_data, mk(recv, 1'b1));
        check(out_tag == 4'(recv), $sformatf("stream%0d_tag", recv), 64'(out_tag), 64'(recv));
        recv++;
        held = 1'b0;
      end else if (out_valid) begin
        held      = 1'b1;
        held_data = out_data;
        held_tag  = out_tag;
      end else begin
        held = 1'b0;
      end
      cyc++;
    end
    check(recv == 10, "stream_count", 64'(recv), 64'd10);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stale = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (out_valid) stale = 1'b1;
    end
    check(stale == 1'b0, "stream_no_dup", 64'(stale), 64'd0);

    // Mid-stream reset with three beats in flight
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = mk(i, 1'b0);
      in_tag   = 4'(i + 5);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    check(out_valid == 1'b1, "inflight_valid", 64'(out_valid), 64'd1);
    check(in_ready == 1'b0,  "inflight_full", 64'(in_ready), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check(out_valid == 1'b0, "async_rst_valid", 64'(out_valid), 64'd0);
    check(out_data == '0,    "async_rst_data", out_data, 64'd0);
    check(out_tag == '0,     "async_rst_tag", 64'(out_tag), 64'd0);
    check(in_ready == 1'b1,  "async_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (out_valid) stale = 1'b1;
    end
    check(stale == 1'b0, "no_stale_after_rst", 64'(stale), 64'd0);
    push_wait(64'h3FC0_3FC0_3FC0_3FC0, 4'hA);
    check(out_data == 64'h408C_408C_408C_408C, "post_rst_data", out_data, 64'h408C_408C_408C_408C);
    check(out_tag == 4'hA, "post_rst_tag", 64'(out_tag), 64'hA);

`ifdef EXP_PIPE_STATUS_EN
    // Saturation status: three flagged beats after a clean one
    @(negedge clk);
    #1;
    check(sat_count == 16'd0, "sat_count_zero", 64'(sat_count), 64'd0);
    push_wait(64'h3F80_3F80_C300_4300, 4'h1);
    check(out_data == 64'h402D_402D_0000_7F80, "sat0_data", out_data, 64'h402D_402D_0000_7F80);
    check(out_ovf == 4'b0001, "sat0_ovf", 64'(out_ovf), 64'b0001);
    check(out_unf == 4'b0010, "sat0_unf", 64'(out_unf), 64'b0010);
    push_wait(64'hFF80_7F80_3F80_3F80, 4'h2);
    check(out_ovf == 4'b0100, "sat1_ovf", 64'(out_ovf), 64'b0100);
    check(out_unf == 4'b1000, "sat1_unf", 64'(out_unf), 64'b1000);
    push_wait(64'hC300_C300_C300_C300, 4'h3);
    check(out_ovf == 4'b0000, "sat2_ovf", 64'(out_ovf), 64'b0000);
    check(out_unf == 4'b1111, "sat2_unf", 64'(out_unf), 64'b1111);
    @(negedge clk);
    #1;
    check(sat_count == 16'd3, "sat_count_three", 64'(sat_count), 64'd3);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/exp_pipe.md
EXP_PIPE -- requirements
Module: exp_pipe

Interface
REQ-001 SHALL have parameter: LANES, 4, number of independent bf16 lanes (1..8).
REQ-002 SHALL have parameter: TAG_W, 4, width of sideband tag carried with each beat (1..16).
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: in_valid  input  1  input beat present.
REQ-006 SHALL have port: in_ready  output  1  pipe accepts beat this cycle.
REQ-007 SHALL have port: in_data  input  16*LANES  bf16 operands, lane i at [16i+15:16i].
REQ-008 SHALL have port: in_tag  input  TAG_W  sideband, returned unchanged with result.
REQ-009 SHALL have port: out_valid  output  1  result beat present.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts beat.
REQ-011 SHALL have port: out_data  output  16*LANES  bf16 exp(x) per lane.
REQ-012 SHALL have port: out_tag  output  TAG_W  tag of the beat on out_data.

Function
REQ-013 SHALL transfer a beat when valid and ready are both high at a rising edge, on either side.
REQ-014 SHALL be 3 stages: S1 register+classify, S2 table lookup+multiply, S3 add+select; latency exactly 3 cycles with out_ready held high.
REQ-015 SHALL sustain one beat per cycle when out_ready=1; ready_k = ~valid_k | ready_(k+1), ready_S3 = out_ready, in_ready = ready_S1.
REQ-016 SHALL collapse bubbles: an empty stage accepts from upstream even while a downstream stage stalls.
REQ-017 SHALL hold out_data/out_tag stable while out_valid=1 and out_ready=0.
REQ-018 SHALL classify per lane on e=x[14:7], m=x[6:0], s=x[15]: NaN (e=255, m!=0); HI (e>133, non-NaN); LO (e<121); MID (121<=e<=133).
REQ-019 SHALL output NaN -> 16'h7FC0; HI with s=0 -> 16'h7F80; HI with s=1 -> 16'h0000; LO -> 16'h3F80.
REQ-020 SHALL compute MID, s=0: base_p[e] + ((m*off_p[e])[22:7]); product 23 bits unsigned, truncation, no rounding.
REQ-021 SHALL compute MID, s=1: base_n[e] - ((m*off_n[e])[22:7]), result clamped to 16'h0000 if the subtraction underflows.
REQ-022 SHALL use positive table (e: base, off): 121:3F82,2; 122:3F84,4; 123:3F88,9; 124:3F91,19; 125:3FA4,47; 126:3FD3,90; 127:402D,191; 128:40EC,366; 129:425A,736; 130:453A,1485; 131:4B07,2952; 132:568F,5906; 133:6DA1,11817.
REQ-023 SHALL use negative table base_n[e] = bf16 round-nearest of exp(-2^(e-127)), off_n[e] = base_n[e] - base_n[e+1] (base_n[134] = 16'h0000), generated offline and fixed in package; base_n[127] = 16'h3EBC.
REQ-024 SHALL treat lanes independently; one lane's class never affects another lane's result.
REQ-025 SHALL never hold or reuse a previous result for any input class; every accepted beat yields a fully defined output.

Reset
REQ-026 SHALL, while rst_n=0, force all stage valid bits, out_valid, out_data and out_tag to 0, independent of clk.
REQ-027 SHALL discard beats in flight on reset assertion; first output after release corresponds to first beat accepted after release.
REQ-028 SHALL drive in_ready=1 during and immediately after reset.

Configuration
REQ-029 SHALL, when EXP_PIPE_STATUS_EN is defined, add outputs out_ovf[LANES] (HI, s=0), out_unf[LANES] (HI s=1 or clamp), aligned with out_data, plus sat_count (16-bit, saturating at FFFF, counts accepted output beats with any flag set, cleared by reset).
REQ-030 SHALL, without EXP_PIPE_STATUS_EN, omit those ports and counter entirely with identical data path and timing.

Structure
REQ-031 SHALL place class enum, bounds (EXP_LO=121, EXP_HI=133), constants (NaN, +Inf, one), and both base/offset tables in package exp_pkg.
REQ-032 SHALL implement per-lane datapath in sub-module exp_lane, instantiated LANES times; handshake/valid control stays in exp_pipe.

Verification
REQ-033 SHALL check lane0 x=16'h3F80 (1.0), out_ready=1 -> 16'h402D on out_data exactly 3 cycles later.
REQ-034 SHALL check x=16'h3FC0 -> 16'h408C; x=16'hBF80 -> 16'h3EBC.
REQ-035 SHALL check x=16'h4300 -> 7F80; x=16'hC300 -> 0000; x=16'h7FC1 -> 7FC0; x=16'h3C00 -> 3F80, all lanes mixed in one beat.
REQ-036 SHALL check back-to-back 10 beats with out_ready toggled 1,0,0,1,...: results and tags in order, no loss/duplication, data stable during stall.
REQ-037 SHALL check rst_n pulsed low mid-stream with 3 beats in flight: out_valid drops asynchronously, no stale beat emerges afterward.
REQ-038 SHALL, with EXP_PIPE_STATUS_EN, check 3 saturating beats -> sat_count=3 and matching out_ovf/out_unf bits.
